// File: rtl/instr_queue_pkg.sv
// MIPS encodings and constants shared by the instruction prefetch queue and its head decoder.
package instr_queue_pkg;

  typedef logic [31:0] size_t;
  typedef logic [4:0]  regaddr_t;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_J       = 6'h02,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_ADDI    = 6'h08,
    OP_ADDIU   = 6'h09,
    OP_SLTI    = 6'h0A,
    OP_ANDI    = 6'h0C,
    OP_ORI     = 6'h0D,
    OP_XORI    = 6'h0E,
    OP_LUI     = 6'h0F,
    OP_LW      = 6'h23,
    OP_SW      = 6'h2B,
    OP_INVALID = 6'h3F
  } opcode_t;

  typedef enum logic [5:0] {
    FUNC_SLL     = 6'h00,
    FUNC_SRL     = 6'h02,
    FUNC_SRA     = 6'h03,
    FUNC_JR      = 6'h08,
    FUNC_ADD     = 6'h20,
    FUNC_ADDU    = 6'h21,
    FUNC_SUB     = 6'h22,
    FUNC_SUBU    = 6'h23,
    FUNC_AND     = 6'h24,
    FUNC_OR      = 6'h25,
    FUNC_XOR     = 6'h26,
    FUNC_NOR     = 6'h27,
    FUNC_SLT     = 6'h2A,
    FUNC_INVALID = 6'h3F
  } func_t;

  localparam size_t IQ_NOP = 32'h0000_0000;

endpackage

// File: rtl/instr_queue_decode.sv
// Combinational MIPS field decoder; raw codes map to enums through case tables so unlisted encodings become *_INVALID.
module instr_decode
  import instr_queue_pkg::*;
(
  input  size_t       i_instr,
  output opcode_t     o_opcode,
  output func_t       o_funct,
  output logic [4:0]  o_shift,
  output regaddr_t    o_rs,
  output regaddr_t    o_rt,
  output regaddr_t    o_rd,
  output logic [15:0] o_immediate,
  output logic [25:0] o_target
);

  function automatic opcode_t to_opcode(input logic [5:0] code);
    case (code)
      6'h00:   to_opcode = OP_SPECIAL;
      6'h02:   to_opcode = OP_J;
      6'h03:   to_opcode = OP_JAL;
      6'h04:   to_opcode = OP_BEQ;
      6'h05:   to_opcode = OP_BNE;
      6'h08:   to_opcode = OP_ADDI;
      6'h09:   to_opcode = OP_ADDIU;
      6'h0A:   to_opcode = OP_SLTI;
      6'h0C:   to_opcode = OP_ANDI;
      6'h0D:   to_opcode = OP_ORI;
      6'h0E:   to_opcode = OP_XORI;
      6'h0F:   to_opcode = OP_LUI;
      6'h23:   to_opcode = OP_LW;
      6'h2B:   to_opcode = OP_SW;
      default: to_opcode = OP_INVALID;
    endcase
  endfunction

  function automatic func_t to_funct(input logic [5:0] code);
    case (code)
      6'h00:   to_funct = FUNC_SLL;
      6'h02:   to_funct = FUNC_SRL;
      6'h03:   to_funct = FUNC_SRA;
      6'h08:   to_funct = FUNC_JR;
      6'h20:   to_funct = FUNC_ADD;
      6'h21:   to_funct = FUNC_ADDU;
      6'h22:   to_funct = FUNC_SUB;
      6'h23:   to_funct = FUNC_SUBU;
      6'h24:   to_funct = FUNC_AND;
      6'h25:   to_funct = FUNC_OR;
      6'h26:   to_funct = FUNC_XOR;
      6'h27:   to_funct = FUNC_NOR;
      6'h2A:   to_funct = FUNC_SLT;
      default: to_funct = FUNC_INVALID;
    endcase
  endfunction

  assign o_opcode    = to_opcode(i_instr[31:26]);
  assign o_funct     = to_funct(i_instr[5:0]);
  assign o_shift     = i_instr[10:6];
  assign o_rs        = i_instr[25:21];
  assign o_rt        = i_instr[20:16];
  assign o_rd        = i_instr[15:11];
  assign o_immediate = i_instr[15:0];
  assign o_target    = i_instr[25:0];

endmodule

// File: rtl/instr_queue.sv
// Instruction prefetch queue: DEPTH-entry FIFO of {word, PC} with valid/ready on both sides and a decoded head.
// Optional feature: define IQ_ILLEGAL_EN for illegal-head detection with a sticky, reset-only illegal latch.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  size_t                 instr_i,
  input  logic [PC_WIDTH-1:0]   pc_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [PC_WIDTH-1:0]   pc_o,
  output opcode_t               opcode_o,
  output func_t                 funct_o,
  output logic [4:0]            shift_o,
  output regaddr_t              rs_o,
  output regaddr_t              rt_o,
  output regaddr_t              rd_o,
  output logic [15:0]           immediate_o,
  output logic [25:0]           target_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                  illegal_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  size_t               r_mem    [DEPTH];
  logic [PC_WIDTH-1:0] r_pc_mem [DEPTH];
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [CNT_W-1:0]    r_count;

  logic    w_in_ready;
  logic    w_out_valid;
  logic    w_push;
  logic    w_pop;
  size_t   w_head_instr;
  opcode_t w_opcode;
  func_t   w_funct;

  assign w_out_valid = (r_count != {CNT_W{1'b0}});
  assign w_push      = in_valid_i && w_in_ready && !flush_i && !reset_i;
  assign w_pop       = w_out_valid && out_ready_i && !flush_i && !reset_i;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]    <= instr_i;
      r_pc_mem[r_wr_ptr] <= pc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i || flush_i) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Empty queue presents a NOP with PC 0 so downstream never sees stale storage.
  assign w_head_instr = w_out_valid ? r_mem[r_rd_ptr] : IQ_NOP;
  assign pc_o         = w_out_valid ? r_pc_mem[r_rd_ptr] : {PC_WIDTH{1'b0}};

  instr_decode u_decode (
    .i_instr     (w_head_instr),
    .o_opcode    (w_opcode),
    .o_funct     (w_funct),
    .o_shift     (shift_o),
    .o_rs        (rs_o),
    .o_rt        (rt_o),
    .o_rd        (rd_o),
    .o_immediate (immediate_o),
    .o_target    (target_o)
  );

`ifdef IQ_ILLEGAL_EN
  logic r_illegal;
  logic w_head_illegal;

  assign w_head_illegal = w_out_valid &&
                          ((w_opcode == OP_INVALID) ||
                           ((w_opcode == OP_SPECIAL) && (w_funct == FUNC_INVALID)));

  // Sticky: survives flush so a redirect cannot hide an executed illegal word.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_illegal <= 1'b0;
    end else if (w_pop && w_head_illegal) begin
      r_illegal <= 1'b1;
    end else begin
      r_illegal <= r_illegal;
    end
  end

  assign w_in_ready = (r_count != FULL) && !r_illegal;
  assign illegal_o  = w_head_illegal || r_illegal;
`else
  assign w_in_ready = (r_count != FULL);
  assign illegal_o  = 1'b0;
`endif

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = w_out_valid;
  assign opcode_o    = w_opcode;
  assign funct_o     = w_funct;
  assign count_o     = r_count;

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: decode vector table plus scoreboarded handshake sequences.
module tb_instr_queue;
  import instr_queue_pkg::*;

  localparam int DEPTH = 4;
`ifdef IQ_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1, flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic        in_ready_o, out_valid_o, illegal_o;
  size_t       instr_i = 32'h0;
  logic [31:0] pc_i = 32'h0, pc_o;
  opcode_t     opcode_o;
  func_t       funct_o;
  logic [4:0]  shift_o;
  regaddr_t    rs_o, rt_o, rd_o;
  logic [15:0] immediate_o;
  logic [25:0] target_o;
  logic [2:0]  count_o;

  instr_queue #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
    .clk(clk), .reset_i(reset_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .instr_i(instr_i), .pc_i(pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .pc_o(pc_o),
    .opcode_o(opcode_o), .funct_o(funct_o), .shift_o(shift_o),
    .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .immediate_o(immediate_o),
    .target_o(target_o), .count_o(count_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {logic [31:0] word; logic [31:0] pc;} ent_t;
  ent_t q[$];
  bit   m_ill = 1'b0;

  typedef struct {
    logic [31:0] word; logic [31:0] pc;
    logic [5:0] op; logic [5:0] fn;
    logic [4:0] rs; logic [4:0] rt; logic [4:0] rd; logic [15:0] imm;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_illegal(input logic [31:0] w);
    logic [5:0] op = w[31:26];
    logic [5:0] fn = w[5:0];
    case (op)
      6'h00: case (fn)
               6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
               6'h24, 6'h25, 6'h26, 6'h27, 6'h2A: return 1'b0;
               default: return 1'b1;
             endcase
      6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C,
      6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Check state visible now, then advance one clock and update the model.
  task automatic tick();
    bit push_ok, pop_ok, exp_ill;
    chk("count", count_o, q.size());
    chk("in_ready", in_ready_o, (q.size() != DEPTH) && !m_ill);
    chk("out_valid", out_valid_o, q.size() != 0);
    exp_ill = m_ill;
    if (q.size() != 0) begin
      if (ILL_EN && is_illegal(q[0].word)) exp_ill = 1'b1;
      chk("head_pc", pc_o, q[0].pc);
      chk("head_target", target_o, q[0].word[25:0]);
    end else begin
      chk("empty_pc", pc_o, 0);
    end
    chk("illegal", illegal_o, exp_ill);
    push_ok = in_valid_i && (q.size() < DEPTH) && !m_ill;
    pop_ok  = out_ready_i && (q.size() != 0);
    @(posedge clk);
    if (reset_i) begin
      q.delete(); m_ill = 1'b0;
    end else if (flush_i) begin
      q.delete();
    end else begin
      if (pop_ok) begin
        if (ILL_EN && is_illegal(q[0].word)) m_ill = 1'b1;
        void'(q.pop_front());
      end
      if (push_ok) q.push_back({instr_i, pc_i});
    end
    #1;
  endtask

  task automatic drive(input logic [31:0] w, input logic [31:0] p);
    in_valid_i = 1'b1; instr_i = w; pc_i = p;
  endtask

  initial begin
    vecs[0] = '{32'h8C22_0004, 32'hBFC0_0000, OP_LW,      FUNC_INVALID, 5'd1, 5'd2, 5'd0,  16'h0004};
    vecs[1] = '{32'h0022_1820, 32'hBFC0_0004, OP_SPECIAL, FUNC_ADD,     5'd1, 5'd2, 5'd3,  16'h1820};
    vecs[2] = '{32'hAC85_FFFC, 32'hBFC0_0008, OP_SW,      FUNC_INVALID, 5'd4, 5'd5, 5'd31, 16'hFFFC};
    vecs[3] = '{32'h1043_0002, 32'hBFC0_000C, OP_BEQ,     FUNC_SRL,     5'd2, 5'd3, 5'd0,  16'h0002};
    vecs[4] = '{32'h0800_0010, 32'hBFC0_0010, OP_J,       FUNC_INVALID, 5'd0, 5'd0, 5'd0,  16'h0010};
    vecs[5] = '{32'h0064_2825, 32'hBFC0_0014, OP_SPECIAL, FUNC_OR,      5'd3, 5'd4, 5'd5,  16'h2825};

    @(posedge clk); @(posedge clk); #1;
    reset_i = 1'b0;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_count", count_o, 0);
    chk("rst_opcode", opcode_o, OP_SPECIAL);
    chk("rst_funct", funct_o, FUNC_SLL);
    chk("rst_illegal", illegal_o, 0);
    tick();

    // Decode table: push, check head one cycle later, hold once for stability, then pop.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].word, vecs[i].pc);
      tick();
      in_valid_i = 1'b0;
      for (int h = 0; h < 2; h++) begin
        chk("vec_valid", out_valid_o, 1);
        chk("vec_pc", pc_o, vecs[i].pc);
        chk("vec_opcode", opcode_o, vecs[i].op);
        chk("vec_funct", funct_o, vecs[i].fn);
        chk("vec_rs", rs_o, vecs[i].rs);
        chk("vec_rt", rt_o, vecs[i].rt);
        chk("vec_rd", rd_o, vecs[i].rd);
        chk("vec_imm", immediate_o, vecs[i].imm);
        chk("vec_shift", shift_o, vecs[i].word[10:6]);
        if (h == 0) tick();
      end
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
    end

    // Fill to DEPTH (pointers start mid-array so they wrap), fifth word dropped, drain in order.
    for (int i = 0; i < 5; i++) begin
      drive(32'h2000_0001 + i, 32'h0000_0100 + 4 * i);
      tick();
    end
    in_valid_i = 1'b0;
    chk("full_count", count_o, 4);
    chk("full_in_ready", in_ready_o, 0);
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    out_ready_i = 1'b0;
    chk("drained_count", count_o, 0);

    // Full with push+pop only pops; at 3 a push+pop holds the count.
    for (int i = 0; i < 4; i++) begin
      drive(32'h2400_0010 + i, 32'h0000_0200 + 4 * i);
      tick();
    end
    drive(32'h2400_00AA, 32'h0000_0300);
    out_ready_i = 1'b1;
    tick();
    chk("full_pushpop_count", count_o, 3);
    drive(32'h2400_00BB, 32'h0000_0304);
    tick();
    chk("pushpop3_count", count_o, 3);
    in_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    out_ready_i = 1'b0;

    // Flush with a concurrent push drops everything.
    drive(32'h0022_1820, 32'h0000_0400);
    tick();
    chk("preflush_funct", funct_o, FUNC_ADD);
    chk("preflush_rd", rd_o, 3);
    drive(32'h0064_2825, 32'h0000_0404);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("flush_count", count_o, 0);
    tick(); tick();
    chk("flush_stays_empty", out_valid_o, 0);

    // Reset mid-stream discards contents.
    drive(32'h2000_0055, 32'h0000_0500);
    tick(); tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0; in_valid_i = 1'b0;
    chk("midrst_count", count_o, 0);
    chk("midrst_valid", out_valid_o, 0);

    // Illegal head and sticky latch (flush must not clear it, reset must).
    drive(32'hFC00_0000, 32'h0000_0600);
    tick();
    in_valid_i = 1'b0;
    chk("ill_head", illegal_o, ILL_EN);
    chk("ill_opcode", opcode_o, OP_INVALID);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk("ill_after_pop", illegal_o, ILL_EN);
    chk("ill_in_ready", in_ready_o, !ILL_EN);
    drive(32'h2000_0077, 32'h0000_0604);
    tick();
    in_valid_i = 1'b0;
    chk("ill_push_count", count_o, ILL_EN ? 0 : 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("ill_after_flush", illegal_o, ILL_EN);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("ill_after_reset", illegal_o, 0);
    chk("ready_after_reset", in_ready_o, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
